// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl_pkg
// Purpose  : Shared types for the MEM-stage access controller.
// Revision : 1.0
// ============================================================================
package mem_access_ctrl_pkg;

    localparam int WORD_W      = 32;
    localparam int WORD_OFFSET = 2;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } memstate_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_link_reg.sv
`default_nettype none
// ============================================================================
// Module   : link_reg
// Purpose  : LL/SC link register with word-granular match and invalidation.
// Revision : 1.0
// ============================================================================
module link_reg
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              set_i,
    input  logic              clr_i,
    input  logic              st_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              inv_i,
    input  logic [ADDR_W-1:0] inv_addr_i,
    output logic              sc_ok_o
);

    localparam logic [ADDR_W-1:0] c_word_mask =
        {{(ADDR_W-WORD_OFFSET){1'b1}}, {WORD_OFFSET{1'b0}}};

    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic              w_hit;
    logic              w_inv_hit;

    // Masked XOR keeps the byte-offset bits out of every comparison.
    assign w_hit     = valid_q && (((addr_q ^ addr_i) & c_word_mask) == '0);
    assign w_inv_hit = inv_i && valid_q && (((addr_q ^ inv_addr_i) & c_word_mask) == '0);
    assign sc_ok_o   = w_hit && !w_inv_hit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else if (set_i) begin
            valid_q <= 1'b1;
            addr_q  <= addr_i;
        end else if (clr_i || (st_i && w_hit) || w_inv_hit) begin
            valid_q <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : MEM-stage data-cache request controller with LL/SC and halt.
// Revision : 1.0
// ============================================================================
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int LINK_EN = 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              dRENi,
    input  logic              dWENi,
    input  logic              is_ll,
    input  logic              is_sc,
    input  logic [ADDR_W-1:0] ALUOut,
    input  word_t             store,
    input  logic              halt_in,
    input  logic              ext_stall,
    input  logic              dhit,
    input  word_t             dmemload,
    input  logic              ccinv,
    input  logic [ADDR_W-1:0] ccaddr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [ADDR_W-1:0] dmemaddr,
    output word_t             dmemstore,
    output word_t             memload,
    output logic              mem_stall,
    output logic              mmwb_en,
    output logic              halt_out
);

    memstate_t state_q, state_d;
    word_t     load_buf_q, load_buf_d;
    logic      halt_q;

    logic  w_is_load, w_is_sc, w_is_mem, w_sc_ok, w_sc_fail;
    logic  w_link_set, w_link_clr, w_st_done;
    word_t w_result;

    // Both enables set is illegal; the store wins.
    assign w_is_load = dRENi && !dWENi;
    assign w_is_sc   = dWENi && is_sc;
    assign w_is_mem  = dRENi || dWENi;
    assign w_sc_fail = w_is_sc && !w_sc_ok;
    assign w_result  = w_is_sc ? word_t'(1) : (w_is_load ? dmemload : '0);

    generate
        if (LINK_EN != 0) begin : g_link
            link_reg #(.ADDR_W(ADDR_W)) u_link (
                .clk_i      (CLK),
                .rst_i      (nRST),
                .set_i      (w_link_set),
                .clr_i      (w_link_clr),
                .st_i       (w_st_done),
                .addr_i     (ALUOut),
                .inv_i      (ccinv),
                .inv_addr_i (ccaddr),
                .sc_ok_o    (w_sc_ok)
            );
        end else begin : g_no_link
            assign w_sc_ok = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        load_buf_d = load_buf_q;
        dmemREN    = 1'b0;
        dmemWEN    = 1'b0;
        dmemaddr   = '0;
        dmemstore  = '0;
        memload    = '0;
        mem_stall  = ext_stall;
        mmwb_en    = !ext_stall;
        w_link_set = 1'b0;
        w_link_clr = 1'b0;
        w_st_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_is_mem && !w_sc_fail) begin
                    dmemREN   = w_is_load;
                    dmemWEN   = dWENi;
                    dmemaddr  = ALUOut;
                    dmemstore = store;
                    mem_stall = 1'b1;
                    mmwb_en   = 1'b0;
                    state_d   = ACCESS;
                end else if (w_sc_fail) begin
                    w_link_clr = 1'b1;
                end
            end
            ACCESS: begin
                dmemREN   = w_is_load;
                dmemWEN   = dWENi;
                dmemaddr  = ALUOut;
                dmemstore = store;
                mem_stall = 1'b1;
                mmwb_en   = 1'b0;
                if (dhit) begin
                    memload    = w_result;
                    load_buf_d = w_result;
                    w_link_set = w_is_load && is_ll;
                    w_link_clr = w_is_sc;
                    w_st_done  = dWENi && !is_sc;
                    if (!ext_stall) begin
                        mem_stall = 1'b0;
                        mmwb_en   = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                // Result is replayed from the buffer; the cache is never re-asked.
                memload = load_buf_q;
                if (!ext_stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (nRST) begin
            dmemREN   = 1'b0;
            dmemWEN   = 1'b0;
            dmemaddr  = '0;
            dmemstore = '0;
            memload   = '0;
            mem_stall = 1'b0;
            mmwb_en   = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state_q    <= IDLE;
            load_buf_q <= '0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_buf_q <= load_buf_d;
            halt_q     <= halt_q || (halt_in && mmwb_en);
        end
    end

    assign halt_out = halt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Directed bench with a behavioural model checked every cycle.
// Revision : 1.0
// ============================================================================
module tb_mem_access_ctrl;

    logic        CLK = 1'b0;
    logic        nRST, dRENi, dWENi, is_ll, is_sc, halt_in, ext_stall, dhit, ccinv;
    logic [31:0] ALUOut, store, dmemload, ccaddr;
    logic        dmemREN, dmemWEN, mem_stall, mmwb_en, halt_out;
    logic [31:0] dmemaddr, dmemstore, memload;

    always #5 CLK = ~CLK;

    mem_access_ctrl #(.ADDR_W(32), .LINK_EN(1)) dut (
        .CLK(CLK), .nRST(nRST), .dRENi(dRENi), .dWENi(dWENi), .is_ll(is_ll),
        .is_sc(is_sc), .ALUOut(ALUOut), .store(store), .halt_in(halt_in),
        .ext_stall(ext_stall), .dhit(dhit), .dmemload(dmemload), .ccinv(ccinv),
        .ccaddr(ccaddr), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .memload(memload), .mem_stall(mem_stall),
        .mmwb_en(mmwb_en), .halt_out(halt_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit wmatch(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

    // Model: one transaction in flight, an optional held result, a link and a halt flag.
    bit          m_inflight = 0, m_holding = 0, m_link_v = 0, m_halt = 0;
    logic [31:0] m_held = '0, m_link_a = '0;

    always @(negedge CLK) begin : compare
        bit          e_ren, e_wen, e_stall, e_en, e_halt, req, ld, sc, mem, ok, inv_hit;
        logic [31:0] e_ml;
        #2;
        if (nRST) begin
            e_ren = 0; e_wen = 0; e_stall = 0; e_en = 1; e_ml = '0; e_halt = 0; req = 0;
            m_inflight = 0; m_holding = 0; m_link_v = 0; m_halt = 0; m_held = '0;
        end else begin
            e_halt  = m_halt;
            ld      = dRENi && !dWENi;
            sc      = dWENi && is_sc;
            mem     = dRENi || dWENi;
            inv_hit = ccinv && m_link_v && wmatch(ccaddr, m_link_a);
            e_ren = 0; e_wen = 0; e_ml = '0; req = 0;
            e_stall = ext_stall; e_en = !ext_stall;
            if (mem) check("legal_rw", {31'b0, dRENi && dWENi}, 32'd0);
            if (m_holding) begin
                e_ml = m_held;
                if (!ext_stall) m_holding = 0;
            end else if (m_inflight) begin
                req = 1;
                if (!dhit) begin
                    e_stall = 1; e_en = 0;
                end else begin
                    e_ml = sc ? 32'd1 : (ld ? dmemload : 32'd0);
                    m_inflight = 0;
                    if (ext_stall) begin
                        m_holding = 1; m_held = e_ml;
                    end
                    if (ld && is_ll) begin
                        m_link_v = 1; m_link_a = ALUOut; inv_hit = 0;
                    end else if (sc || (dWENi && wmatch(ALUOut, m_link_a))) begin
                        m_link_v = 0;
                    end
                end
            end else begin
                ok = m_link_v && wmatch(ALUOut, m_link_a) && !inv_hit;
                if (mem && !(sc && !ok)) begin
                    req = 1; e_stall = 1; e_en = 0; m_inflight = 1;
                end else if (sc) begin
                    m_link_v = 0;
                end
            end
            if (inv_hit) m_link_v = 0;
            if (req) begin
                e_ren = ld; e_wen = dWENi;
            end
            m_halt = m_halt || (halt_in && e_en);
        end
        check("cmp_ren",     {31'b0, dmemREN},   {31'b0, e_ren});
        check("cmp_wen",     {31'b0, dmemWEN},   {31'b0, e_wen});
        check("cmp_stall",   {31'b0, mem_stall}, {31'b0, e_stall});
        check("cmp_mmwb_en", {31'b0, mmwb_en},   {31'b0, e_en});
        check("cmp_memload", memload,            e_ml);
        check("cmp_halt",    {31'b0, halt_out},  {31'b0, e_halt});
        if (req) begin
            check("cmp_addr",  dmemaddr,  ALUOut);
            check("cmp_store", dmemstore, store);
        end
    end

    logic        s_ren, s_wen, s_stall, s_en, s_halt;
    logic [31:0] s_ml;
    int          ren_cnt, stall_cnt;

    task automatic idle();
        dRENi = 0; dWENi = 0; is_ll = 0; is_sc = 0; dhit = 0;
        ccinv = 0; halt_in = 0; ext_stall = 0;
    endtask

    task automatic cyc();
        #2;
        s_ren = dmemREN; s_wen = dmemWEN; s_stall = mem_stall;
        s_en = mmwb_en; s_ml = memload; s_halt = halt_out;
        @(negedge CLK);
    endtask

    task automatic do_ll(input logic [31:0] addr, input bit inv_at_hit);
        idle(); dRENi = 1; is_ll = 1; ALUOut = addr; cyc();
        dhit = 1; dmemload = 32'h11; ccinv = inv_at_hit; ccaddr = addr; cyc();
        idle(); cyc();
    endtask

    task automatic do_sw(input logic [31:0] addr);
        idle(); dWENi = 1; ALUOut = addr; store = 32'hAA; cyc();
        dhit = 1; cyc();
        idle(); cyc();
    endtask

    task automatic sc_try(input logic [31:0] addr, input bit exp_ok, input bit inv_now, input string tag);
        idle(); dWENi = 1; is_sc = 1; ALUOut = addr; store = 32'h5;
        ccinv = inv_now; ccaddr = 32'h200;
        cyc();
        check({tag, "_wen"},   {31'b0, s_wen},   {31'b0, exp_ok});
        check({tag, "_stall"}, {31'b0, s_stall}, {31'b0, exp_ok});
        if (s_wen) begin
            ccinv = 0; dhit = 1; cyc();
            check({tag, "_result"}, s_ml, 32'd1);
        end else begin
            check({tag, "_result"}, s_ml, 32'd0);
        end
        idle(); cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        nRST = 1; idle(); ALUOut = '0; store = '0; dmemload = '0; ccaddr = '0;
        repeat (2) @(negedge CLK);
        nRST = 0;
        cyc();
        check("rst_stall", {31'b0, s_stall}, 32'd0);
        check("rst_en",    {31'b0, s_en},    32'd1);
        check("rst_ren",   {31'b0, s_ren},   32'd0);
        check("rst_halt",  {31'b0, s_halt},  32'd0);

        // Load with two wait cycles
        dRENi = 1; ALUOut = 32'h100; cyc();
        ren_cnt = int'(s_ren); stall_cnt = int'(s_stall);
        cyc();
        ren_cnt += int'(s_ren); stall_cnt += int'(s_stall);
        dhit = 1; dmemload = 32'hDEADBEEF; cyc();
        ren_cnt += int'(s_ren); stall_cnt += int'(s_stall);
        check("ld_data", s_ml, 32'hDEADBEEF);
        check("ld_en",   {31'b0, s_en}, 32'd1);
        idle(); dmemload = '0; cyc();
        check("ld_ren_after", {31'b0, s_ren}, 32'd0);
        check("ld_ren_cycles",   ren_cnt,   32'd3);
        check("ld_stall_cycles", stall_cnt, 32'd2);

        // Hit under downstream stall, then two HOLD cycles
        dRENi = 1; cyc();
        dhit = 1; ext_stall = 1; dmemload = 32'hDEADBEEF; cyc();
        dhit = 0; dmemload = 32'h12345678;
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("hold_ren", {31'b0, s_ren}, 32'd0);
            check("hold_ml",  s_ml, 32'hDEADBEEF);
            check("hold_en",  {31'b0, s_en}, 32'd0);
        end
        ext_stall = 0; cyc();
        check("hold_rel_en", {31'b0, s_en}, 32'd1);
        check("hold_rel_ml", s_ml, 32'hDEADBEEF);
        check("hold_rel_ren", {31'b0, s_ren}, 32'd0);
        idle(); cyc();

        // LL/SC pairs
        do_ll(32'h200, 0); sc_try(32'h200, 1, 0, "sc_ok");
        sc_try(32'h200, 0, 0, "sc_after_clr");
        do_ll(32'h200, 0); idle(); ccinv = 1; ccaddr = 32'h200; cyc();
        sc_try(32'h200, 0, 0, "sc_inv");
        do_ll(32'h200, 0); do_sw(32'h204); sc_try(32'h200, 1, 0, "sc_sw_other");
        do_ll(32'h200, 0); do_sw(32'h200); sc_try(32'h200, 0, 0, "sc_sw_same");
        do_ll(32'h200, 1); sc_try(32'h202, 1, 0, "sc_ll_beats_inv");
        do_ll(32'h200, 0); sc_try(32'h200, 0, 1, "sc_inv_beats_sc");

        // Stall in idle, then sticky halt
        idle(); ext_stall = 1; halt_in = 1; cyc();
        check("idle_stall", {31'b0, s_stall}, 32'd1);
        check("idle_en",    {31'b0, s_en},    32'd0);
        idle(); cyc();
        check("halt_blocked", {31'b0, s_halt}, 32'd0);
        halt_in = 1; cyc();
        idle(); cyc();
        check("halt_set", {31'b0, s_halt}, 32'd1);
        cyc();
        check("halt_sticky", {31'b0, s_halt}, 32'd1);

        // Reset mid-access
        do_ll(32'h200, 0);
        dRENi = 1; ALUOut = 32'h100; cyc();
        #2;
        check("pre_rst_ren", {31'b0, dmemREN}, 32'd1);
        #1 nRST = 1;
        #1 check("rst_async_ren", {31'b0, dmemREN}, 32'd0);
        @(negedge CLK);
        idle(); cyc();
        nRST = 0; cyc();
        check("post_rst_stall", {31'b0, s_stall}, 32'd0);
        check("post_rst_en",    {31'b0, s_en},    32'd1);
        check("post_rst_halt",  {31'b0, s_halt},  32'd0);
        sc_try(32'h200, 0, 0, "sc_post_rst");

        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
